pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-stage register, the generic successor of the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque packed payload of DATA_W bits under a valid/ready handshake. A stall holds the payload instead of destroying it, and a flush inserts a configurable bubble. An optional second (skid) entry registers the upstream ready, so back-pressure never forms a combinational path through the stage.

## Interface
Parameters:
- DATA_W, 128, payload width in bits (≥1); the stage concatenates its control/data fields into this vector.
- BUBBLE_VAL, {DATA_W{1'b0}}, payload presented on out_data_o whenever out_valid_o is 0 (e.g. encodes ALU_ADD / dest ALU / no write).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry with combinational in_ready_o.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  reset is synchronous and active-high.
- flush_i  in  1  discard every entry held or being accepted this cycle.
- in_valid_i  in  1  upstream offers in_data_i.
- in_ready_o  out  1  stage can accept; transfer when in_valid_i && in_ready_o.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  out_data_o is a live instruction.
- out_ready_i  in  1  downstream consumes; transfer when out_valid_o && out_ready_i.
- out_data_o  out  DATA_W  head entry, or BUBBLE_VAL when not valid.
- occupancy_o  out  2  number of live entries, 0..2 (0..1 when SKID=0).

## Operation
- State: main entry (main_v, main_d) drives the outputs. With SKID=1 there is also a skid entry (skid_v, skid_d).
- Reset, or flush_i without reset: main_v=0 and skid_v=0 next cycle. Data registers may keep their contents, but out_data_o shows BUBBLE_VAL. Reset has priority over flush.
- flush_i=1: any input handshake in the same cycle is dropped. The upstream producer still sees its handshake complete.
- SKID=1, in_ready_o = !skid_v, taken from a register only.
  - Accept while main is empty, or main is leaving this cycle: the data goes to main.
  - Accept while main is held (out_valid_o && !out_ready_i): the data goes to skid. The next cycle, in_ready_o=0.
  - Output pop while skid_v=1: skid moves to main and skid_v clears. No new accept can occur in that cycle, because in_ready_o was 0.
- SKID=0:
  - in_ready_o = !main_v || out_ready_i.
  - Accept loads main.
  - Pop without accept clears main_v.
- Hold: when out_ready_i=0, out_data_o and out_valid_o stay bit-stable for as long as that lasts.
- Order: FIFO. Entries are never duplicated or reordered.
- occupancy_o = main_v + skid_v.

## Timing
- Reset values: out_valid_o=0, out_data_o=BUBBLE_VAL, in_ready_o=1, occupancy_o=0. These appear from the first edge with reset=1. All inputs are ignored while reset=1.
- Latency: accept at edge N gives out_valid_o=1 with that data after edge N.
- Throughput: 1 transfer/cycle sustained when out_ready_i=1.
- SKID=1 back-pressure: when out_ready_i drops with a full stream, exactly one extra beat is absorbed and in_ready_o falls on the following cycle. When out_ready_i rises again, in_ready_o returns 1 one cycle after the skid entry drains.
- Simultaneous accept + pop on a one-entry stage: the new data replaces main and occupancy stays 1.
- Flush + out_ready_i in the same cycle: a downstream pop of the current head still counts, because the handshake is seen. Only the state changes after the edge.

## Structure
- Shared package/parameters header:
  - bubble encodings (ALU_ADD, dest ALU, reg_wr=0, mem_wr=0);
  - per-stage payload field widths and offsets.
- Each stage wrapper builds its BUBBLE_VAL from these.
- No sub-module needed. Flat implementation, with the SKID variants selected by generate.

## Test plan
- Reset: assert reset 2 cycles with in_valid_i=1, in_data_i=0xAA…. Required response: out_valid_o=0, out_data_o=BUBBLE_VAL, in_ready_o=1, occupancy_o=0.
- Streaming: 8 beats 0x1..0x8 with out_ready_i=1. Required response: out_data_o = 0x1..0x8 on consecutive cycles, each one cycle after its accept, no gaps.
- Stall (SKID=1): stream 0x1,0x2,0x3 and drop out_ready_i while 0x1 is at the head.
  - Required while stalled: 0x2 lands in skid; in_ready_o=0 from the next cycle; 0x1 holds for 4 cycles.
  - Required on release: the order out is 0x1,0x2,0x3 with no loss.
- Flush: flush_i with occupancy 2, plus a simultaneous input 0x9. Required response: next cycle out_valid_o=0, out_data_o=BUBBLE_VAL, occupancy_o=0, and 0x9 never appears.
- SKID=0: out_ready_i=0 with main full. Required: in_ready_o=0 in the same cycle. Raising out_ready_i with in_valid_i=1 swaps the data in one cycle.
- Reset mid-stall with occupancy 2: all state clears next cycle. The first beat after reset deasserts emerges normally.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline-stage registers: occupancy type,
// bubble control encodings and the EX-stage control field layout.
package pipe_stage_reg_pkg;

    typedef logic [1:0] occ_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5
    } aluOp_e;

    typedef enum logic [1:0] {
        DEST_ALU = 2'd0,
        DEST_MEM = 2'd1,
        DEST_PC  = 2'd2
    } dest_e;

    localparam int EX_ALUOP_OFF = 0;
    localparam int EX_ALUOP_W   = 4;
    localparam int EX_DEST_OFF  = 4;
    localparam int EX_DEST_W    = 2;
    localparam int EX_REGWR_OFF = 6;
    localparam int EX_MEMWR_OFF = 7;
    localparam int EX_CTRL_W    = 8;

    // Bubble control word: ALU_ADD, result to ALU, no register or memory write.
    function automatic logic [EX_CTRL_W-1:0] exCtrlBubble();
        logic [EX_CTRL_W-1:0] ctrl;
        ctrl = '0;
        ctrl[EX_ALUOP_OFF +: EX_ALUOP_W] = ALU_ADD;
        ctrl[EX_DEST_OFF +: EX_DEST_W]   = DEST_ALU;
        ctrl[EX_REGWR_OFF]               = 1'b0;
        ctrl[EX_MEMWR_OFF]               = 1'b0;
        return ctrl;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline-stage register with stall hold, flush-to-bubble
// and an optional skid entry that keeps in_ready_o purely registered.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W     = 128,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter bit                SKID       = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output occ_t              occupancy_o
);

    logic              r_mainValid;
    logic [DATA_W-1:0] r_mainData;
    logic              w_skidValid;
    logic              w_pop;
    logic              w_accept;

    assign w_pop    = r_mainValid && out_ready_i;
    assign w_accept = in_valid_i && in_ready_o;

    generate
        if (SKID) begin : g_skid
            logic              r_skidValid;
            logic [DATA_W-1:0] r_skidData;

            // A pending skid entry blocks upstream, so it only ever drains into main.
            always_ff @(posedge clk) begin
                if (reset || flush_i) begin
                    r_mainValid <= 1'b0;
                    r_skidValid <= 1'b0;
                end else if (r_skidValid) begin
                    if (w_pop) begin
                        r_mainData  <= r_skidData;
                        r_skidValid <= 1'b0;
                    end
                end else if (w_accept) begin
                    if (!r_mainValid || w_pop) begin
                        r_mainData  <= in_data_i;
                        r_mainValid <= 1'b1;
                    end else begin
                        r_skidData  <= in_data_i;
                        r_skidValid <= 1'b1;
                    end
                end else if (w_pop) begin
                    r_mainValid <= 1'b0;
                end
            end

            assign w_skidValid = r_skidValid;
            assign in_ready_o  = !r_skidValid;
        end else begin : g_single
            always_ff @(posedge clk) begin
                if (reset || flush_i) begin
                    r_mainValid <= 1'b0;
                end else if (w_accept) begin
                    r_mainData  <= in_data_i;
                    r_mainValid <= 1'b1;
                end else if (w_pop) begin
                    r_mainValid <= 1'b0;
                end
            end

            assign w_skidValid = 1'b0;
            assign in_ready_o  = !r_mainValid || out_ready_i;
        end
    endgenerate

    assign out_valid_o = r_mainValid;
    assign out_data_o  = r_mainValid ? r_mainData : BUBBLE_VAL;
    assign occupancy_o = {1'b0, r_mainValid} + {1'b0, w_skidValid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 stage with shared stimulus; per-DUT scoreboards
// check FIFO order while each scenario task checks handshake details inline.
module tb_pipe_stage_reg;

    localparam int          W      = 16;
    localparam logic [15:0] BUBBLE = 16'hB0B0;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          inValid;
    logic          outReady;
    logic [W-1:0]  inData;

    logic          sInReady, sOutValid, nInReady, nOutValid;
    logic [W-1:0]  sOutData, nOutData;
    logic [1:0]    sOcc, nOcc;

    int            compared   = 0;
    int            mismatched = 0;
    logic [W-1:0]  sQ[$];
    logic [W-1:0]  nQ[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(W), .BUBBLE_VAL(BUBBLE), .SKID(1'b1)) dutSkid (
        .clk(clk), .reset(reset), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(sInReady), .in_data_i(inData),
        .out_valid_o(sOutValid), .out_ready_i(outReady), .out_data_o(sOutData),
        .occupancy_o(sOcc)
    );

    pipe_stage_reg #(.DATA_W(W), .BUBBLE_VAL(BUBBLE), .SKID(1'b0)) dutSingle (
        .clk(clk), .reset(reset), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(nInReady), .in_data_i(inData),
        .out_valid_o(nOutValid), .out_ready_i(outReady), .out_data_o(nOutData),
        .occupancy_o(nOcc)
    );

    // One clock: scoreboard both DUTs at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [W-1:0] exp;
        @(negedge clk);
        if (sOutValid && outReady) begin
            compared++;
            if (sQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL skid_sb_order: got %h, expected nothing", sOutData);
            end else begin
                exp = sQ.pop_front();
                if (sOutData !== exp) begin
                    mismatched++;
                    $display("[TB] FAIL skid_sb_order: got %h, expected %h", sOutData, exp);
                end
            end
        end
        if (!sOutValid) begin
            compared++;
            if (sOutData !== BUBBLE) begin
                mismatched++;
                $display("[TB] FAIL skid_bubble: got %h, expected %h", sOutData, BUBBLE);
            end
        end
        if (nOutValid && outReady) begin
            compared++;
            if (nQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL single_sb_order: got %h, expected nothing", nOutData);
            end else begin
                exp = nQ.pop_front();
                if (nOutData !== exp) begin
                    mismatched++;
                    $display("[TB] FAIL single_sb_order: got %h, expected %h", nOutData, exp);
                end
            end
        end
        if (!nOutValid) begin
            compared++;
            if (nOutData !== BUBBLE) begin
                mismatched++;
                $display("[TB] FAIL single_bubble: got %h, expected %h", nOutData, BUBBLE);
            end
        end
        if (reset || flush) begin
            sQ.delete();
            nQ.delete();
        end else begin
            if (inValid && sInReady === 1'b1) sQ.push_back(inData);
            if (inValid && nInReady === 1'b1) nQ.push_back(inData);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; inValid = 1'b1; inData = 16'hAAAA; outReady = 1'b1;
        tick();
        tick();
        reset = 1'b0; inValid = 1'b0;
        compared++;
        if ({sOutValid, sInReady, sOcc, sOutData} !== {1'b0, 1'b1, 2'd0, BUBBLE}) begin
            mismatched++;
            $display("[TB] FAIL reset_skid: got v=%b r=%b occ=%0d d=%h, expected v=0 r=1 occ=0 d=%h",
                     sOutValid, sInReady, sOcc, sOutData, BUBBLE);
        end
        compared++;
        if ({nOutValid, nInReady, nOcc, nOutData} !== {1'b0, 1'b1, 2'd0, BUBBLE}) begin
            mismatched++;
            $display("[TB] FAIL reset_single: got v=%b r=%b occ=%0d d=%h, expected v=0 r=1 occ=0 d=%h",
                     nOutValid, nInReady, nOcc, nOutData, BUBBLE);
        end
    endtask

    task automatic test_streaming();
        outReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            inValid = 1'b1;
            inData  = W'(i);
            tick();
            compared++;
            if (sOutValid !== 1'b1 || sOutData !== W'(i) || sOcc !== 2'd1) begin
                mismatched++;
                $display("[TB] FAIL stream_skid: got v=%b d=%h occ=%0d, expected v=1 d=%h occ=1",
                         sOutValid, sOutData, sOcc, W'(i));
            end
            compared++;
            if (nOutValid !== 1'b1 || nOutData !== W'(i)) begin
                mismatched++;
                $display("[TB] FAIL stream_single: got v=%b d=%h, expected v=1 d=%h",
                         nOutValid, nOutData, W'(i));
            end
        end
        inValid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        outReady = 1'b1; inValid = 1'b1; inData = 16'h0001;
        tick();
        outReady = 1'b0; inData = 16'h0002;
        tick();
        compared++;
        if (sOcc !== 2'd2 || sInReady !== 1'b0 || sOutData !== 16'h0001) begin
            mismatched++;
            $display("[TB] FAIL stall_skid_absorb: got occ=%0d r=%b d=%h, expected occ=2 r=0 d=0001",
                     sOcc, sInReady, sOutData);
        end
        inData = 16'h0003;
        for (int k = 0; k < 3; k++) begin
            tick();
            compared++;
            if (sOutValid !== 1'b1 || sOutData !== 16'h0001 || sInReady !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL stall_hold: got v=%b d=%h r=%b, expected v=1 d=0001 r=0",
                         sOutValid, sOutData, sInReady);
            end
        end
        outReady = 1'b1;
        tick();
        compared++;
        if (sOutData !== 16'h0002 || sInReady !== 1'b1 || sOcc !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL stall_drain: got d=%h r=%b occ=%0d, expected d=0002 r=1 occ=1",
                     sOutData, sInReady, sOcc);
        end
        tick();
        compared++;
        if (sOutData !== 16'h0003) begin
            mismatched++;
            $display("[TB] FAIL stall_third: got %h, expected 0003", sOutData);
        end
        inValid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        outReady = 1'b1; inValid = 1'b1; inData = 16'h0004;
        tick();
        outReady = 1'b0; inData = 16'h0005;
        tick();
        compared++;
        if (sOcc !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL flush_setup_occ: got %0d, expected 2", sOcc);
        end
        flush = 1'b1; inData = 16'h0009;
        tick();
        flush = 1'b0; inValid = 1'b0;
        compared++;
        if (sOutValid !== 1'b0 || sOutData !== BUBBLE || sOcc !== 2'd0 || sInReady !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL flush_clear: got v=%b d=%h occ=%0d r=%b, expected v=0 d=%h occ=0 r=1",
                     sOutValid, sOutData, sOcc, sInReady, BUBBLE);
        end
        compared++;
        if (nOutValid !== 1'b0 || nOcc !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL flush_single: got v=%b occ=%0d, expected v=0 occ=0", nOutValid, nOcc);
        end
        outReady = 1'b1;
        tick();
        tick();
        // Flush together with a pop of the head: the pop is still scoreboarded.
        inValid = 1'b1; inData = 16'h000A;
        tick();
        inValid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        compared++;
        if (sOutValid !== 1'b0 || nOutValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL flush_with_pop: got v=%b/%b, expected v=0/0", sOutValid, nOutValid);
        end
    endtask

    task automatic test_skid0();
        outReady = 1'b1; inValid = 1'b1; inData = 16'h0006;
        tick();
        outReady = 1'b0; inData = 16'h0007;
        #1;
        compared++;
        if (nInReady !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_ready_comb: got %b, expected 0", nInReady);
        end
        tick();
        compared++;
        if (nOutData !== 16'h0006 || nOutValid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_hold: got v=%b d=%h, expected v=1 d=0006", nOutValid, nOutData);
        end
        outReady = 1'b1;
        #1;
        compared++;
        if (nInReady !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_ready_rise: got %b, expected 1", nInReady);
        end
        tick();
        compared++;
        if (nOutData !== 16'h0007 || nOcc !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL single_swap: got d=%h occ=%0d, expected d=0007 occ=1", nOutData, nOcc);
        end
        inValid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        outReady = 1'b1; inValid = 1'b1; inData = 16'h0011;
        tick();
        outReady = 1'b0; inData = 16'h0012;
        tick();
        compared++;
        if (sOcc !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL rststall_setup_occ: got %0d, expected 2", sOcc);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compared++;
        if (sOutValid !== 1'b0 || sOcc !== 2'd0 || sInReady !== 1'b1 || sOutData !== BUBBLE) begin
            mismatched++;
            $display("[TB] FAIL rststall_clear: got v=%b occ=%0d r=%b d=%h, expected v=0 occ=0 r=1 d=%h",
                     sOutValid, sOcc, sInReady, sOutData, BUBBLE);
        end
        inData = 16'h0013; outReady = 1'b1;
        tick();
        compared++;
        if (sOutValid !== 1'b1 || sOutData !== 16'h0013 || nOutData !== 16'h0013) begin
            mismatched++;
            $display("[TB] FAIL rststall_first: got v=%b d=%h/%h, expected v=1 d=0013/0013",
                     sOutValid, sOutData, nOutData);
        end
        inValid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_skid0();
        test_reset_mid_stall();
        compared++;
        if (sQ.size() != 0 || nQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain_empty: got %0d/%0d pending, expected 0/0", sQ.size(), nQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
